clocked_index_reverse_buffer: RTL and testbench
===============================================

# clocked_index_reverse_buffer

Parametrised, clocked successor of the combinational array-reversal test model. It accepts DEPTH words over a valid/ready stream and stores them in an internal array. It then replays them in reversed or original order, and publishes a registered snapshot of the stored array. It is used as a sequential regression block for the HDL-to-simulation-model flow, exercising arrays, counters, handshakes and an FSM under one clock with asynchronous reset.

## Interface
- DATA_W, 8, word width in bits (>=1)
- DEPTH, 10, words per frame (>=2)
- CNT_W, $clog2(DEPTH+1), width of fill/drain counters (derived, not overridden)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort: discard frame, return to FILL
- mode  input  1  0 = reversed replay, 1 = in-order replay; sampled on the last fill handshake
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts a word this cycle
- in_data  input  DATA_W  input word
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts a word this cycle
- out_data  output  DATA_W  replayed word
- out_last  output  1  out_data is the final word of the frame
- out_mem  output  DATA_W x DEPTH, indices [0:DEPTH-1]  registered snapshot of the frame in replay order
- fill_count  output  CNT_W  words accepted in the current frame

## Operation
- States: FILL and DRAIN. Reset and flush both enter FILL.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: mem[fill_count] <= in_data and fill_count increments.
  - On the handshake that makes fill_count reach DEPTH:
    - latch mode into mode_q;
    - load out_mem: out_mem[i] = word i if mode=1, word DEPTH-1-i if mode=0. This includes the word being accepted on that edge.
    - Next state is DRAIN and fill_count clears to 0.
- DRAIN:
  - in_ready=0 and out_valid=1.
  - out_data = out_mem[rd_idx]. rd_idx starts at 0 and increments on out_valid&&out_ready.
  - out_last=1 when rd_idx==DEPTH-1.
  - Handshake with out_last: next state is FILL and rd_idx clears to 0.
- out_mem holds its value until the next frame completes. It is not cleared on return to FILL.
- flush (synchronous, highest priority after reset):
  - state goes to FILL; fill_count and rd_idx go to 0.
  - out_valid=0 on the next cycle; out_mem is not modified.
  - A word presented in the flush cycle is not stored.
- mode changes during FILL or DRAIN have no effect on the current frame.
- All arithmetic is unsigned. Counters never exceed DEPTH, so there is no wrap past DEPTH.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=FILL, in_ready=1, out_valid=0, out_last=0;
  - out_data=0, all out_mem entries 0, fill_count=0, rd_idx=0, mode_q=0.
- Reset asserted mid-frame aborts it immediately. Outputs reach reset values without waiting for clk.
- in_ready, out_valid and out_last are decoded from registered state only. They have no combinational path from in_valid or out_ready.
- Fill throughput is one word per cycle.
- Latency:
  - out_valid rises on the cycle after the last fill handshake.
  - The first output word is valid then.
  - in_ready rises on the cycle after the out_last handshake.
- Minimum frame period is 2*DEPTH cycles, with no overlap between fill and drain.
- out_ready low holds out_data/out_last stable. Backpressure of any length is allowed.
- in_valid low stalls fill; fill_count holds.

## Test plan
- Reset sequence: drive rst_n=0 asynchronously mid-cycle with DEPTH=4, DATA_W=8 → all outputs 0 and in_ready=1 before the next clk edge.
- Reversed frame: mode=0, stream 0x11,0x22,0x33,0x44 back-to-back with out_ready=1.
  - out_mem = {0x44,0x33,0x22,0x11}.
  - out_data sequence 0x44,0x33,0x22,0x11 on 4 consecutive cycles starting 1 cycle after the last accept; out_last only on 0x11.
  - in_ready returns the cycle after.
- In-order frame with mode toggled mid-fill: mode=1 sampled on the last word; words 0xA0..0xA3 → replay 0xA0,0xA1,0xA2,0xA3. Mode toggles during drain do not change the replay.
- Stalls: random in_valid gaps and out_ready low for 3 cycles mid-drain → out_data held constant during the stall, no words lost or duplicated, fill_count tracks accepts exactly.
- Flush: flush after 2 of 4 words, then a fresh frame 0x01..0x04 with mode=0 → replay 0x04..0x01. The previous out_mem is held until the new frame completes.
- Reset mid-drain: rst_n low at rd_idx=2 → out_valid=0 and out_mem=0 immediately. The next frame behaves as after power-up.

Source files
------------

// File: rtl/clocked_index_reverse_buffer_if.sv
// Stream interface for clocked_index_reverse_buffer.
// Carries the fill-side and drain-side valid/ready handshakes.
interface clocked_index_reverse_buffer_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/clocked_index_reverse_buffer.sv
// Frame buffer: fills DEPTH words, then replays them reversed or in order.
// Publishes a registered snapshot of the frame in replay order.
module clocked_index_reverse_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 10,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic mode,
   clocked_index_reverse_buffer_if.slave bus,
   output logic [DATA_W-1:0] out_mem [0:DEPTH-1],
   output logic [CNT_W-1:0] fill_count
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      FILL,
      DRAIN
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [CNT_W-1:0]  rd_idx;
   logic              in_hs;
   logic              out_hs;
   logic              last_fill;

   assign bus.in_ready  = (state == FILL);
   assign bus.out_valid = (state == DRAIN);
   assign bus.out_last  = (state == DRAIN) &&
                          (rd_idx == CNT_W'(DEPTH - 1));
   assign bus.out_data  = out_mem[rd_idx[AW-1:0]];

   assign in_hs     = bus.in_valid && (state == FILL);
   assign out_hs    = bus.out_ready && (state == DRAIN);
   assign last_fill = in_hs &&
                      (fill_count == CNT_W'(DEPTH - 1));

   // Frame FSM: fill counter, word store, snapshot load and replay index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         fill_count <= '0;
         rd_idx     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i]     <= '0;
            out_mem[i] <= '0;
         end
      end else if (flush) begin
         state      <= FILL;
         fill_count <= '0;
         rd_idx     <= '0;
      end else begin
         unique case (state)
            FILL: begin
               if (in_hs) begin
                  mem[fill_count[AW-1:0]] <= bus.in_data;
                  if (last_fill) begin
                     // The final word is not in mem yet; take it from the bus.
                     for (int i = 0; i < DEPTH; i++) begin
                        if (mode)
                           out_mem[i] <= (i == DEPTH - 1) ?
                                         bus.in_data : mem[i];
                        else
                           out_mem[i] <= (i == 0) ?
                                         bus.in_data : mem[DEPTH-1-i];
                     end
                     fill_count <= '0;
                     state      <= DRAIN;
                  end else begin
                     fill_count <= fill_count + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (bus.out_last) begin
                     rd_idx <= '0;
                     state  <= FILL;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_clocked_index_reverse_buffer.sv
// Bench for clocked_index_reverse_buffer at DEPTH=4, DATA_W=8.
// Frame vectors from a table; replayed words checked through a queue.
module tb_clocked_index_reverse_buffer;
   localparam int DATA_W = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic flush = 1'b0;
   logic mode = 1'b0;
   logic [DATA_W-1:0] out_mem [0:DEPTH-1];
   logic [CNT_W-1:0] fill_count;

   clocked_index_reverse_buffer_if #(.DATA_W(DATA_W)) bus ();

   clocked_index_reverse_buffer #(
      .DATA_W(DATA_W),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .mode(mode),
      .bus(bus),
      .out_mem(out_mem),
      .fill_count(fill_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       m;
      logic [7:0] w [4];
      logic [7:0] mem [4];
      bit         gaps;
      int         stall_at;
   } vec_t;

   vec_t vecs [4];
   int checks = 0;
   int errors = 0;
   logic [8:0] q [$];
   logic [8:0] mon_exp;
   logic [8:0] prev_out;
   bit prev_stall = 0;
   logic [7:0] held [4];
   int ncyc;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_mem(input string tag, input logic [7:0] e [4]);
      for (int k = 0; k < DEPTH; k++)
         chk(tag, int'(out_mem[k]), int'(e[k]));
   endtask

   // Scoreboard: pop and compare on each output handshake, check stall hold.
   always @(negedge clk) begin
      if (prev_stall && bus.out_valid)
         chk("hold", int'({bus.out_last, bus.out_data}), int'(prev_out));
      if (bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            mon_exp = q.pop_front();
            chk("out_word", int'({bus.out_last, bus.out_data}),
                int'(mon_exp));
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_last, bus.out_data};
   end

   task automatic fill(input logic [7:0] w [4], input logic m,
                       input bit gaps);
      for (int i = 0; i < DEPTH; i++) begin
         if (gaps) begin
            int g = int'($urandom_range(0, 2));
            bus.in_valid = 1'b0;
            repeat (g) begin
               step();
               chk("fill_hold", int'(fill_count), i);
            end
         end
         chk("in_ready_fill", int'(bus.in_ready), 1);
         chk("fill_count", int'(fill_count), i);
         bus.in_valid = 1'b1;
         bus.in_data = w[i];
         mode = (i == DEPTH - 1) ? m : ~m;
         if (i == DEPTH - 1)
            for (int k = 0; k < DEPTH; k++)
               q.push_back({(k == DEPTH - 1),
                            (m ? w[k] : w[DEPTH-1-k])});
         step();
      end
      bus.in_valid = 1'b0;
      mode = ~m;
      chk("out_valid_after_fill", int'(bus.out_valid), 1);
      chk("in_ready_after_fill", int'(bus.in_ready), 0);
      chk("fill_count_clear", int'(fill_count), 0);
   endtask

   task automatic drain(input int stall_at, input bit toggle,
                        output int n);
      n = 0;
      bus.out_ready = 1'b1;
      while (q.size() > 0 && n < 40) begin
         if (n == stall_at) begin
            bus.out_ready = 1'b0;
            repeat (3) step();
            bus.out_ready = 1'b1;
         end
         if (toggle) mode = ~mode;
         step();
         n++;
      end
      chk("drain_left", q.size(), 0);
      q.delete();
      chk("in_ready_after_drain", int'(bus.in_ready), 1);
      chk("out_valid_after_drain", int'(bus.out_valid), 0);
   endtask

   task automatic run_vec(input int v);
      fill(vecs[v].w, vecs[v].m, vecs[v].gaps);
      chk_mem("out_mem", vecs[v].mem);
      drain(vecs[v].stall_at, 1'b1, ncyc);
      if (vecs[v].stall_at < 0)
         chk("drain_cycles", ncyc, DEPTH);
   endtask

   task automatic chk_reset_state();
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_fill_count", int'(fill_count), 0);
      for (int k = 0; k < DEPTH; k++)
         chk("rst_out_mem", int'(out_mem[k]), 0);
   endtask

   initial begin
      vecs[0].m = 1'b0;
      vecs[0].w = '{8'h11, 8'h22, 8'h33, 8'h44};
      vecs[0].mem = '{8'h44, 8'h33, 8'h22, 8'h11};
      vecs[0].gaps = 0;
      vecs[0].stall_at = -1;
      vecs[1].m = 1'b1;
      vecs[1].w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      vecs[1].mem = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      vecs[1].gaps = 0;
      vecs[1].stall_at = -1;
      vecs[2].m = 1'b0;
      vecs[2].w = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
      vecs[2].mem = '{8'hF0, 8'h0F, 8'hC3, 8'h5A};
      vecs[2].gaps = 1;
      vecs[2].stall_at = 1;
      vecs[3].m = 1'b1;
      vecs[3].w = '{8'h01, 8'h80, 8'h7E, 8'hFF};
      vecs[3].mem = '{8'h01, 8'h80, 8'h7E, 8'hFF};
      vecs[3].gaps = 1;
      vecs[3].stall_at = 2;

      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;

      // asynchronous reset mid-cycle
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_reset_state();
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int v = 0; v < 4; v++)
         run_vec(v);

      // reset mid-drain at rd_idx=2
      fill(vecs[0].w, 1'b0, 0);
      bus.out_ready = 1'b1;
      step();
      step();
      chk("mid_drain_data", int'(bus.out_data), 8'h22);
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset_state();
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_vec(0);

      // flush during drain
      fill(vecs[1].w, 1'b1, 0);
      bus.out_ready = 1'b1;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.out_ready = 1'b0;
      q.delete();
      chk("flush_out_valid", int'(bus.out_valid), 0);
      chk("flush_in_ready", int'(bus.in_ready), 1);
      chk_mem("flush_mem_kept", vecs[1].mem);

      // flush after 2 of 4 words, then a fresh reversed frame
      bus.in_valid = 1'b1;
      bus.in_data = 8'hEE;
      step();
      bus.in_data = 8'hDD;
      step();
      chk("fill_two", int'(fill_count), 2);
      flush = 1'b1;
      bus.in_data = 8'hBB;
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_fill_count", int'(fill_count), 0);
      chk("flush_fill_out_valid", int'(bus.out_valid), 0);
      chk_mem("flush_fill_mem_kept", vecs[1].mem);
      held = '{8'h01, 8'h02, 8'h03, 8'h04};
      fill(held, 1'b0, 0);
      held = '{8'h04, 8'h03, 8'h02, 8'h01};
      chk_mem("post_flush_mem", held);
      drain(-1, 1'b0, ncyc);
      chk("post_flush_cycles", ncyc, DEPTH);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
